clk_stim_gen: RTL
=================

Name: clk_stim_gen

Overview:
- Programmable clock-stimulus generator: the transmit-side counterpart of the clock-monitor/noise-detector path.
- Synthesises an output clock with independently programmable high and low durations, counted in `clk` cycles.
- Injects controlled glitches (inverted pulses of programmable width) on command.
- Drives the monitored-clock input of the monitor in self-test and board bring-up, so FAIL/noise detection can be exercised deterministically.

Parameters:
- WIDTH, 8, width of high/low duration fields.
- GW, 4, width of glitch-length field.
- DEF_HIGH, 10, active high duration after reset.
- DEF_LOW, 10, active low duration after reset.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  run request for generated clock.
- cfg_valid  input  1  new duration pair offered.
- cfg_ready  output  1  shadow register empty; accepts cfg.
- cfg_high  input  WIDTH  high duration, cycles.
- cfg_low  input  WIDTH  low duration, cycles.
- cfg_err  output  1  one-cycle pulse: offered cfg rejected.
- glitch_req  input  1  request glitch injection.
- glitch_len  input  GW  glitch width, cycles.
- glitch_ack  output  1  one-cycle pulse: glitch finished.
- clk_out  output  1  generated clock, registered.
- period_start  output  1  one-cycle pulse on first HIGH cycle of each period.
- busy  output  1  FSM not IDLE.

Behaviour:

Reset values:
- clk_out=0, period_start=0, glitch_ack=0, cfg_err=0, busy=0, cfg_ready=1.
- Active config = DEF_HIGH/DEF_LOW; shadow empty; glitch pending cleared.
- Reset has priority over every event, including mid-period and mid-glitch.

Config handshake:
- Transfer occurs when cfg_valid&&cfg_ready.
- If cfg_high==0 or cfg_low==0: pulse cfg_err the next cycle, discard the request, leave the shadow empty, keep cfg_ready=1.
- Otherwise write the shadow; cfg_ready=0 from the next cycle until the shadow is loaded.
- Shadow → active copy happens only at a period boundary: when entering HIGH from IDLE or from LOW. cfg_ready returns to 1 in that same cycle.
- A valid transfer in IDLE applies to the first period.

FSM states: IDLE, HIGH, LOW, GLITCH.
- IDLE: clk_out=0. On enable=1 → HIGH the next cycle (one-cycle latency); period_start=1 that cycle.
- HIGH: clk_out=1 for exactly active_high cycles, excluding glitch cycles. Then → LOW.
- LOW: clk_out=0 for exactly active_low cycles. Then:
  - enable=1 → HIGH (new period, period_start).
  - enable=0 → IDLE.
- enable deasserted mid-HIGH/LOW: the current period completes; no truncation.
- Phase counter: counts down from duration-1; the phase ends when the counter reaches 0.

Glitch injection:
- A glitch_req sampled in HIGH or LOW sets pending.
- In the next cycle the FSM enters GLITCH and saves the phase and remaining count.
- GLITCH: clk_out = inverse of the saved phase level for max(glitch_len,1) cycles; glitch_len is latched at request. The phase counter is frozen.
- After GLITCH, the FSM returns to the saved phase with the remaining count intact; glitch_ack pulses on the first cycle back.
- Total period is lengthened by the glitch length.
- If the request arrives on the last cycle of a phase, the glitch is applied at the start of the following phase, with the inverse of that phase's level. If the following state is IDLE, the glitch is dropped with no ack.
- glitch_req in IDLE or GLITCH is ignored (no ack).
- Simultaneous glitch_req and period boundary: the boundary is taken first and the glitch is inserted in the new phase.

Arithmetic:
- Counters are WIDTH/GW unsigned. Maximum period is 2*(2^WIDTH-1) cycles plus glitch cycles; no wrap.

busy:
- busy=1 whenever state≠IDLE.

Test Plan:
- rst 3 cycles, enable=1: clk_out high 10 / low 10; period_start every 20 cycles; first HIGH one cycle after enable.
- While running, cfg 3/5 accepted mid-HIGH: current period stays 10/10; cfg_ready=0 until the boundary; subsequent periods are high 3, low 5, period_start every 8.
- cfg_high=0 with cfg_valid: cfg_err pulse one cycle later; cfg_ready stays 1; durations unchanged.
- 10/10 running, glitch_req with glitch_len=2 on 4th HIGH cycle: clk_out low 2 cycles, then high 6 more cycles; glitch_ack pulses; that period is 22 cycles.
- glitch_len=0: glitch of exactly 1 cycle.
- enable dropped on 2nd HIGH cycle: period completes (8 high + 10 low); FSM then IDLE, busy=0, clk_out=0.
- rst asserted during GLITCH: next cycle clk_out=0, busy=0, cfg_ready=1, no glitch_ack; durations back to 10/10.

Source files
------------

// File: rtl/clk_stim_gen.sv
// Programmable clock-stimulus generator: synthesises a clock with independent high/low
// durations (in clk cycles) and injects inverted glitch pulses on request.
module clk_stim_gen #(
    parameter int WIDTH    = 8,
    parameter int GW       = 4,
    parameter int DEF_HIGH = 10,
    parameter int DEF_LOW  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_high,
    input  logic [WIDTH-1:0] cfg_low,
    output logic             cfg_err,
    input  logic             glitch_req,
    input  logic [GW-1:0]    glitch_len,
    output logic             glitch_ack,
    output logic             clk_out,
    output logic             period_start,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, GLITCH} state_t;

    state_t           state, next_state, phase_next;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic [GW-1:0]    gcnt, gcnt_n, glen_m1;
    logic             saved_high, saved_high_n;
    logic             start_pend, start_pend_n;
    logic [WIDTH-1:0] active_high, active_low;
    logic [WIDTH-1:0] shadow_high, shadow_low;
    logic             shadow_full;
    logic [WIDTH-1:0] eff_high, eff_low;
    logic             cfg_xfer, cfg_bad, cfg_good;
    logic             new_period;
    logic             clk_out_n, ps_n, ack_n;

    assign cfg_ready = !shadow_full;
    assign busy      = (state != IDLE);
    assign cfg_xfer  = cfg_valid && !shadow_full;
    assign cfg_bad   = (cfg_high == '0) || (cfg_low == '0);
    assign cfg_good  = cfg_xfer && !cfg_bad;
    assign glen_m1   = (glitch_len == '0) ? '0 : glitch_len - GW'(1);

    // A config accepted on the very boundary cycle bypasses the shadow and applies at once.
    assign eff_high = shadow_full ? shadow_high : (cfg_good ? cfg_high : active_high);
    assign eff_low  = shadow_full ? shadow_low  : (cfg_good ? cfg_low  : active_low);

    always_comb begin
        phase_next   = state;
        next_state   = state;
        cnt_n        = cnt;
        gcnt_n       = gcnt;
        saved_high_n = saved_high;
        start_pend_n = start_pend;
        new_period   = 1'b0;
        ack_n        = 1'b0;
        ps_n         = 1'b0;
        clk_out_n    = 1'b0;

        unique case (state)
            IDLE: begin
                if (enable) begin
                    phase_next = HIGH;
                    new_period = 1'b1;
                    cnt_n      = eff_high - WIDTH'(1);
                end
            end
            HIGH: begin
                if (cnt == '0) begin
                    phase_next = LOW;
                    cnt_n      = active_low - WIDTH'(1);
                end else begin
                    cnt_n = cnt - WIDTH'(1);
                end
            end
            LOW: begin
                if (cnt == '0) begin
                    if (enable) begin
                        phase_next = HIGH;
                        new_period = 1'b1;
                        cnt_n      = eff_high - WIDTH'(1);
                    end else begin
                        phase_next = IDLE;
                    end
                end else begin
                    cnt_n = cnt - WIDTH'(1);
                end
            end
            GLITCH: begin
                if (gcnt == '0) begin
                    phase_next   = saved_high ? HIGH : LOW;
                    ack_n        = 1'b1;
                    ps_n         = start_pend && saved_high;
                    start_pend_n = 1'b0;
                end else begin
                    gcnt_n = gcnt - GW'(1);
                end
            end
            default: phase_next = IDLE;
        endcase

        next_state = phase_next;

        // The phase counter already holds the remaining count, so it simply freezes in GLITCH.
        if ((state == HIGH || state == LOW) && glitch_req && phase_next != IDLE) begin
            next_state   = GLITCH;
            saved_high_n = (phase_next == HIGH);
            start_pend_n = new_period;
            gcnt_n       = glen_m1;
        end

        if (new_period && next_state == HIGH) begin
            ps_n = 1'b1;
        end

        unique case (next_state)
            HIGH:    clk_out_n = 1'b1;
            GLITCH:  clk_out_n = !saved_high_n;
            default: clk_out_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            gcnt         <= '0;
            saved_high   <= 1'b0;
            start_pend   <= 1'b0;
            active_high  <= WIDTH'(DEF_HIGH);
            active_low   <= WIDTH'(DEF_LOW);
            shadow_high  <= '0;
            shadow_low   <= '0;
            shadow_full  <= 1'b0;
            clk_out      <= 1'b0;
            period_start <= 1'b0;
            glitch_ack   <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            state        <= next_state;
            cnt          <= cnt_n;
            gcnt         <= gcnt_n;
            saved_high   <= saved_high_n;
            start_pend   <= start_pend_n;
            clk_out      <= clk_out_n;
            period_start <= ps_n;
            glitch_ack   <= ack_n;
            cfg_err      <= cfg_xfer && cfg_bad;

            if (new_period) begin
                active_high <= eff_high;
                active_low  <= eff_low;
                shadow_full <= 1'b0;
            end else if (cfg_good) begin
                shadow_high <= cfg_high;
                shadow_low  <= cfg_low;
                shadow_full <= 1'b1;
            end
        end
    end

endmodule
